// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
// Shared CPU package: default datapath widths and the architectural register
// numbers that the control and jump-and-link logic refer to by name.
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    // True when the address names the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W_DEF-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_if
// Bundles the MEM/WB write port, the two ID-stage read ports and the debug
// read port of the register file.
//   master : pipeline/ID side -- drives write request and read addresses,
//            receives read data.
//   slave  : register file side.
// -----------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data
    );

endinterface

// File: rtl/wb_regfile_bypass.sv
// -----------------------------------------------------------------------------
// wb_regfile_bypass
// Combinational read-port mux. Produces the final read data for one port:
// zero for register 0, the in-flight writeback data when the port reads the
// register being written this cycle (BYPASS=1, out of reset), else the stored
// value.
// Ports:
//   reset        in  active-low reset; suppresses forwarding while low
//   rd_addr      in  read address
//   stored_data  in  stored value of reg[rd_addr]
//   wr_en/wr_addr/wr_data in  current writeback request
//   rd_data      out final read data
// -----------------------------------------------------------------------------
module wb_regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic BYPASS_ON = (BYPASS != 0);

    // Read-data select: zero register first, then same-cycle forward, then storage.
    always_comb begin
        rd_data = stored_data;
        if (rd_addr == '0) begin
            rd_data = '0;
        end else if (BYPASS_ON && (reset == 1'b1) && (wr_en == 1'b1) && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end else begin
            rd_data = stored_data;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// 32 x 32-bit MIPS general register file at the consumer end of MEM/WB.
// One write port (rising edge), two combinational ID-stage read ports with
// optional write-through forwarding, and an unforwarded debug read port.
// Register 0 has no storage and always reads zero.
// Ports:
//   clk    in  clock, writes on rising edge
//   reset  in  asynchronous active-low reset, clears all storage
//   bus    slave modport of wb_regfile_if (write port, read ports A/B, debug)
// -----------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    wb_regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DATA_W-1:0] view_s [0:DEPTH-1];
    logic              wr_qual_s;

    // Write request qualified by enable first so an unknown address or data
    // with wr_en low can never reach the storage enables.
    always_comb begin
        if ((bus.wr_en == 1'b1) && (bus.wr_addr != '0)) begin
            wr_qual_s = 1'b1;
        end else begin
            wr_qual_s = 1'b0;
        end
    end

    // Next-state per register: load writeback data only on a qualified address match.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            if (wr_qual_s && (bus.wr_addr == ADDR_W'(i))) begin
                regs_d[i] = bus.wr_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage flops; reset clears asynchronously and blocks writes while held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Full-range read view with register 0 tied to zero.
    always_comb begin
        view_s[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            view_s[i] = regs_q[i];
        end
    end

    assign bus.dbg_data = view_s[bus.dbg_addr];

    wb_regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_bypass_a (
        .reset       (reset),
        .rd_addr     (bus.rd_addr_a),
        .stored_data (view_s[bus.rd_addr_a]),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .rd_data     (bus.rd_data_a)
    );

    wb_regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_bypass_b (
        .reset       (reset),
        .rd_addr     (bus.rd_addr_b),
        .stored_data (view_s[bus.rd_addr_b]),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .rd_data     (bus.rd_data_b)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Drives a BYPASS=1 and a BYPASS=0 register file with identical stimulus and
// compares every read port against an array model of the register file.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    logic [31:0] ref_mem [32];
    logic [31:0] wr_seen;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_byp ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_nob ();

    assign bus_nob.wr_en     = bus_byp.wr_en;
    assign bus_nob.wr_addr   = bus_byp.wr_addr;
    assign bus_nob.wr_data   = bus_byp.wr_data;
    assign bus_nob.rd_addr_a = bus_byp.rd_addr_a;
    assign bus_nob.rd_addr_b = bus_byp.rd_addr_b;
    assign bus_nob.dbg_addr  = bus_byp.dbg_addr;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Value a read port must return given the architectural rules.
    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit fwd);
        if (addr == 5'd0) return 32'd0;
        if (reset !== 1'b1) return 32'd0;
        if (fwd && (bus_byp.wr_en === 1'b1) && (bus_byp.wr_addr == addr)) return bus_byp.wr_data;
        return ref_mem[addr];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        bus_byp.wr_en     = we;
        bus_byp.wr_addr   = wa;
        bus_byp.wr_data   = wd;
        bus_byp.rd_addr_a = ra;
        bus_byp.rd_addr_b = rb;
        bus_byp.dbg_addr  = da;
    endtask

    // Advance one clock, apply the write rule to the model, settle 1 time unit.
    task automatic step();
        @(posedge clk);
        if (reset === 1'b1 && bus_byp.wr_en === 1'b1) begin
            wr_seen[bus_byp.wr_addr] = 1'b1;
            if (bus_byp.wr_addr != 5'd0) ref_mem[bus_byp.wr_addr] = bus_byp.wr_data;
        end
        #1;
    endtask

    task automatic check_all_ports(input string tag);
        check_val({tag, "_a"},      bus_byp.rd_data_a, exp_read(bus_byp.rd_addr_a, 1'b1));
        check_val({tag, "_b"},      bus_byp.rd_data_b, exp_read(bus_byp.rd_addr_b, 1'b1));
        check_val({tag, "_dbg"},    bus_byp.dbg_data,  exp_read(bus_byp.dbg_addr, 1'b0));
        check_val({tag, "_nob_a"},  bus_nob.rd_data_a, exp_read(bus_byp.rd_addr_a, 1'b0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        wr_seen  = 32'd0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #12;
        reset = 1'b1;
        @(posedge clk); #1;

        // ---- Reset: preload reg5, assert reset mid-cycle with a write pending
        drive(1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd5, 5'd5);
        step();
        check_val("preload_dbg", bus_byp.dbg_data, 32'h0000_1234);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        #1;
        check_val("rst_a",   bus_byp.rd_data_a, 32'd0);
        check_val("rst_b",   bus_byp.rd_data_b, 32'd0);
        check_val("rst_dbg", bus_byp.dbg_data,  32'd0);
        step();
        check_val("rst_edge_a", bus_byp.rd_data_a, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i));
            #1;
            check_val("post_rst_a",   bus_byp.rd_data_a, 32'd0);
            check_val("post_rst_b",   bus_byp.rd_data_b, 32'd0);
            check_val("post_rst_dbg", bus_byp.dbg_data,  32'd0);
        end
        @(posedge clk); #1;

        // ---- Basic write/read and held value with wr_en low
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd8);
        step();
        drive(1'b0, 5'd8, 32'hFFFF_FFFF, 5'd8, 5'd8, 5'd8);
        #1;
        check_val("basic_a",   bus_byp.rd_data_a, 32'hDEAD_BEEF);
        check_val("basic_dbg", bus_byp.dbg_data,  32'hDEAD_BEEF);
        check_val("basic_nob", bus_nob.rd_data_a, 32'hDEAD_BEEF);
        step();
        check_val("hold_a",   bus_byp.rd_data_a, 32'hDEAD_BEEF);
        check_val("hold_dbg", bus_byp.dbg_data,  32'hDEAD_BEEF);

        // ---- Zero register write is a no-op everywhere
        drive(1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("zero_pre_a", bus_byp.rd_data_a, 32'd0);
        check_val("zero_pre_b", bus_byp.rd_data_b, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("zero_post_a", bus_byp.rd_data_a, 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus_byp.dbg_addr = 5'(i);
            #1;
            check_val("zero_others", bus_byp.dbg_data, (i == 8) ? 32'hDEAD_BEEF : 32'd0);
        end

        // ---- Bypass on both ports, debug shows pre-write then new value
        drive(1'b1, 5'd9, 32'h0000_0011, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd9, 32'h0000_0022, 5'd9, 5'd9, 5'd9);
        #1;
        check_val("byp_a",     bus_byp.rd_data_a, 32'h0000_0022);
        check_val("byp_b",     bus_byp.rd_data_b, 32'h0000_0022);
        check_val("byp_dbg",   bus_byp.dbg_data,  32'h0000_0011);
        check_val("nobyp_a",   bus_nob.rd_data_a, 32'h0000_0011);
        check_val("nobyp_b",   bus_nob.rd_data_b, 32'h0000_0011);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
        #1;
        check_val("byp_post_dbg", bus_byp.dbg_data,  32'h0000_0022);
        check_val("byp_post_nob", bus_nob.rd_data_a, 32'h0000_0022);

        // ---- Dual-port independence
        drive(1'b1, 5'd3, 32'h0000_0003, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd4, 32'h0000_0004, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd4, 32'h0000_0044, 5'd3, 5'd4, 5'd4);
        #1;
        check_val("dual_a",   bus_byp.rd_data_a, 32'h0000_0003);
        check_val("dual_b",   bus_byp.rd_data_b, 32'h0000_0044);
        check_val("dual_dbg", bus_byp.dbg_data,  32'h0000_0004);
        step();

        // ---- Random stress against the array model
        wr_seen = 32'd0;
        for (int c = 0; c < 10000; c++) begin
            logic        we;
            logic [4:0]  wa;
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            if (c < 32) begin
                we = 1'b1;
                wa = 5'(c);
            end
            drive(we, wa, $urandom(), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) bus_byp.rd_addr_b = bus_byp.rd_addr_a;
            if (we && $urandom_range(0, 3) == 0) bus_byp.rd_addr_a = wa;
            if (!we && $urandom_range(0, 7) == 0) begin
                bus_byp.wr_addr = 'x;
                bus_byp.wr_data = 'x;
            end
            #2;
            check_all_ports("rnd");
            step();
        end
        check_val("rnd_cov", wr_seen, 32'hFFFF_FFFF);

        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            bus_byp.dbg_addr = 5'(i);
            #1;
            check_val("final_dbg", bus_byp.dbg_data, (i == 0) ? 32'd0 : ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
